// File: rtl/input_vc_buffer_if.sv
// input_vc_buffer_if: link write side, router read strobe
// and popped-flit return for one router input port.
interface input_vc_buffer_if #(
  parameter int NUM_VC     = 4,
  parameter int FLIT_WIDTH = 32,
  parameter int VC_BITS    = $clog2(NUM_VC)
);
  logic                  in_valid;
  logic [VC_BITS-1:0]    in_vc;
  logic                  in_head;
  logic                  in_tail;
  logic [FLIT_WIDTH-1:0] in_data;
  logic                  rd_valid;
  logic [VC_BITS-1:0]    rd_vc;
  logic                  out_valid;
  logic [VC_BITS-1:0]    out_vc;
  logic [FLIT_WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    output in_vc,
    output in_head,
    output in_tail,
    output in_data,
    output rd_valid,
    output rd_vc,
    input  out_valid,
    input  out_vc,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_vc,
    input  in_head,
    input  in_tail,
    input  in_data,
    input  rd_valid,
    input  rd_vc,
    output out_valid,
    output out_vc,
    output out_data
  );
endinterface

// File: rtl/input_vc_buffer.sv
// input_vc_buffer: per-port VC FIFOs feeding the buffer-read stage.
// Define CREDIT_RETURN_EN to drive credit_valid/credit_vc on pops.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

module input_vc_buffer #(
  parameter int NUM_VC     = 4,
  parameter int VC_DEPTH   = 4,
  parameter int FLIT_WIDTH = `FLIT_DATA_WIDTH,
  parameter int VC_BITS    = $clog2(NUM_VC),
  parameter int CNT_BITS   = $clog2(VC_DEPTH) + 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input_vc_buffer_if.slave                 bus,
  output logic [NUM_VC-1:0][FLIT_WIDTH-1:0] head_data,
  output logic [NUM_VC-1:0]                vc_empty,
  output logic [NUM_VC-1:0]                vc_available,
  output logic                             credit_valid,
  output logic [VC_BITS-1:0]               credit_vc,
  output logic                             overflow_err
);

  localparam int PTR_BITS = $clog2(VC_DEPTH);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } vc_state_t;

  vc_state_t           state  [NUM_VC];
  logic [PTR_BITS-1:0] wr_ptr [NUM_VC];
  logic [PTR_BITS-1:0] rd_ptr [NUM_VC];
  logic [CNT_BITS-1:0] cnt    [NUM_VC];

  // slot = {tail, data}
  logic [FLIT_WIDTH:0] mem [NUM_VC][VC_DEPTH];

  logic [NUM_VC-1:0] wr_sel;
  logic [NUM_VC-1:0] rd_sel;
  logic [NUM_VC-1:0] wr_go;
  logic [NUM_VC-1:0] rd_go;
  logic [NUM_VC-1:0] full;
  logic [FLIT_WIDTH:0] pop_word;
  logic drop;

  // Out-of-range VC indices shift the select bit off the top.
  always_comb begin
    wr_sel = bus.in_valid ?
      (NUM_VC'(1) << bus.in_vc) : '0;
    rd_sel = bus.rd_valid ?
      (NUM_VC'(1) << bus.rd_vc) : '0;
    full         = '0;
    vc_empty     = '0;
    vc_available = '0;
    rd_go        = '0;
    wr_go        = '0;
    head_data    = '0;
    pop_word     = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      full[v]     = cnt[v] == CNT_BITS'(VC_DEPTH);
      vc_empty[v] = cnt[v] == '0;
      rd_go[v]    = rd_sel[v] && !vc_empty[v];
      wr_go[v]    = wr_sel[v] &&
                    (!full[v] || rd_go[v]);
      vc_available[v] = (state[v] == IDLE) &&
                        vc_empty[v];
      head_data[v] =
        mem[v][rd_ptr[v]][FLIT_WIDTH-1:0];
      if (rd_go[v])
        pop_word = mem[v][rd_ptr[v]];
    end
    drop = |(wr_sel & ~wr_go);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        state[v]  <= IDLE;
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        cnt[v]    <= '0;
      end
      overflow_err  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_vc    <= '0;
      bus.out_data  <= '0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (wr_go[v])
          wr_ptr[v] <= wr_ptr[v] + PTR_BITS'(1);
        if (rd_go[v])
          rd_ptr[v] <= rd_ptr[v] + PTR_BITS'(1);
        case ({wr_go[v], rd_go[v]})
          2'b10:   cnt[v] <= cnt[v] + CNT_BITS'(1);
          2'b01:   cnt[v] <= cnt[v] - CNT_BITS'(1);
          default: ;
        endcase
        unique case (state[v])
          IDLE:
            if (wr_go[v] && bus.in_head &&
                !bus.in_tail)
              state[v] <= ACTIVE;
          ACTIVE:
            if (rd_go[v] && pop_word[FLIT_WIDTH])
              state[v] <= IDLE;
        endcase
      end
      if (drop)
        overflow_err <= 1'b1;
      bus.out_valid <= |rd_go;
      if (|rd_go) begin
        bus.out_vc   <= bus.rd_vc;
        bus.out_data <= pop_word[FLIT_WIDTH-1:0];
      end
    end
  end

  // Storage is deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (!reset && wr_go[v])
        mem[v][wr_ptr[v]] <=
          {bus.in_tail, bus.in_data};
    end
  end

`ifdef CREDIT_RETURN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      credit_valid <= 1'b0;
      credit_vc    <= '0;
    end else begin
      credit_valid <= |rd_go;
      if (|rd_go)
        credit_vc <= bus.rd_vc;
    end
  end
`else
  assign credit_valid = 1'b0;
  assign credit_vc    = '0;
`endif

endmodule

// File: tb/tb_input_vc_buffer.sv
// tb_input_vc_buffer: directed test-plan cases plus random traffic
// checked every cycle against a queue-based model of the VC buffer.
module tb_input_vc_buffer;
  localparam int NV = 4;
  localparam int D  = 4;
  localparam int FW = 32;
  localparam int VB = 2;

  logic clk = 1'b0;
  logic reset;
  logic [NV-1:0][FW-1:0] head_data;
  logic [NV-1:0] vc_empty;
  logic [NV-1:0] vc_available;
  logic credit_valid;
  logic [VB-1:0] credit_vc;
  logic overflow_err;

  input_vc_buffer_if #(.NUM_VC(NV), .FLIT_WIDTH(FW)) bus ();

  input_vc_buffer #(
    .NUM_VC(NV), .VC_DEPTH(D), .FLIT_WIDTH(FW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .head_data(head_data),
    .vc_empty(vc_empty),
    .vc_available(vc_available),
    .credit_valid(credit_valid),
    .credit_vc(credit_vc),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model: per-VC packet queues of {tail, data}
  logic [FW:0] q [NV][$];
  bit          m_act [NV];
  bit          m_ovf;
  bit          m_ov;
  logic [VB-1:0] m_ovc;
  logic [FW-1:0] m_odata;
  bit          m_cv;
  logic [VB-1:0] m_cvc;
  bit          m_init = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic void apply();
    int wv, rv;
    bit rok, win, wok;
    bit prev [NV];
    logic [FW:0] f;
    if (reset) begin
      for (int v = 0; v < NV; v++) begin
        q[v].delete();
        m_act[v] = 0;
      end
      m_ovf = 0; m_ov = 0; m_ovc = '0;
      m_odata = '0; m_cv = 0; m_cvc = '0;
      m_init = 1;
      return;
    end
    prev = m_act;
    wv  = int'(bus.in_vc);
    rv  = int'(bus.rd_vc);
    rok = bus.rd_valid && rv < NV &&
          q[rv].size() > 0;
    win = bus.in_valid && wv < NV;
    wok = win && (q[wv].size() < D ||
                  (rok && rv == wv));
    m_ov = rok;
    m_cv = rok;
    if (rok) begin
      f = q[rv].pop_front();
      m_ovc   = VB'(rv);
      m_cvc   = VB'(rv);
      m_odata = f[FW-1:0];
      if (prev[rv] && f[FW]) m_act[rv] = 0;
    end
    if (wok) begin
      q[wv].push_back({bus.in_tail, bus.in_data});
      if (!prev[wv] && bus.in_head && !bus.in_tail)
        m_act[wv] = 1;
    end
    if (win && !wok) m_ovf = 1;
  endfunction

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (m_init) begin
      logic [FW:0] h;
      chk("out_valid", bus.out_valid, m_ov);
      if (m_ov) begin
        chk("out_vc", bus.out_vc, m_ovc);
        chk("out_data", bus.out_data, m_odata);
      end
      chk("overflow_err", overflow_err, m_ovf);
`ifdef CREDIT_RETURN_EN
      chk("credit_valid", credit_valid, m_cv);
      if (m_cv) chk("credit_vc", credit_vc, m_cvc);
`else
      chk("credit_valid_off", credit_valid, 0);
      chk("credit_vc_off", credit_vc, 0);
`endif
      for (int v = 0; v < NV; v++) begin
        chk("vc_empty", vc_empty[v], q[v].size() == 0);
        chk("vc_available", vc_available[v],
            !m_act[v] && q[v].size() == 0);
        if (q[v].size() > 0) begin
          h = q[v][0];
          chk("head_data", head_data[v], h[FW-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    apply();
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.in_vc = '0;
    bus.in_head = 0;  bus.in_tail = 0;
    bus.in_data = '0;
    bus.rd_valid = 0; bus.rd_vc = '0;
  endtask

  task automatic wr(input int vc, input bit hd,
                    input bit tl, input int dat);
    bus.in_valid = 1; bus.in_vc = VB'(vc);
    bus.in_head = hd; bus.in_tail = tl;
    bus.in_data = FW'(dat);
  endtask

  task automatic rd(input int vc);
    bus.rd_valid = 1; bus.rd_vc = VB'(vc);
  endtask

  task automatic chk_credit(input int vc);
`ifdef CREDIT_RETURN_EN
    chk("lit_credit_valid", credit_valid, 1);
    chk("lit_credit_vc", credit_vc, vc);
`else
    chk("lit_credit_off", credit_valid, 0);
`endif
  endtask

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    chk("rst_empty", vc_empty, 4'hF);
    chk("rst_avail", vc_available, 4'hF);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_ovf", overflow_err, 0);

    // single-flit packet on VC2
    wr(2, 1, 1, 'hA5); tick(); idle();
    chk("a5_empty", vc_empty, 4'b1011);
    chk("a5_avail", vc_available, 4'b1011);
    chk("a5_head", head_data[2], 'hA5);
    rd(2); tick(); idle();
    chk("a5_ov", bus.out_valid, 1);
    chk("a5_ovc", bus.out_vc, 2);
    chk("a5_odata", bus.out_data, 'hA5);
    chk("a5_avail2", vc_available, 4'hF);
    chk_credit(2);

    // fill VC1 then overflow
    wr(1, 1, 0, 'h10); tick();
    wr(1, 0, 0, 'h11); tick();
    wr(1, 0, 0, 'h12); tick();
    wr(1, 0, 1, 'h13); tick();
    wr(1, 0, 0, 'h14); tick(); idle();
    chk("vc1_ovf", overflow_err, 1);
    for (int i = 0; i < 4; i++) begin
      rd(1); tick(); idle();
      chk("vc1_pop", bus.out_data, 'h10 + i);
      chk("vc1_avail", vc_available[1], i == 3);
    end
    reset = 1; tick(); reset = 0;
    chk("ovf_cleared", overflow_err, 0);

    // full VC0 with write+pop, pointer wrap
    for (int i = 0; i < 4; i++) begin
      wr(0, i == 0, 0, 'h20 + i); tick();
    end
    for (int i = 0; i < 4; i++) begin
      wr(0, 0, i == 3, 'h24 + i); rd(0);
      tick(); idle();
      chk("wrap_pop", bus.out_data, 'h20 + i);
      chk("wrap_ovf", overflow_err, 0);
      chk("wrap_nonempty", vc_empty[0], 0);
    end
    for (int i = 0; i < 4; i++) begin
      rd(0); tick(); idle();
      chk("wrap_pop2", bus.out_data, 'h24 + i);
    end
    chk("wrap_avail", vc_available[0], 1);

    // read of empty VC3
    rd(3); tick(); idle();
    chk("empty_rd_ov", bus.out_valid, 0);
    chk("empty_rd_cv", credit_valid, 0);
    chk("empty_rd_empty", vc_empty, 4'hF);

    // interleaved VC0 / VC3
    for (int k = 0; k < 8; k++) begin
      wr((k % 2) ? 3 : 0, k < 2, k >= 6, 'h30 + k);
      tick();
    end
    idle();
    for (int j = 0; j < 8; j++) begin
      rd((j % 2) ? 3 : 0); tick(); idle();
      chk("il_ovc", bus.out_vc, (j % 2) ? 3 : 0);
      chk("il_odata", bus.out_data, 'h30 + j);
    end

    // reset mid-packet; write during reset ignored
    wr(1, 1, 0, 'h40); tick();
    wr(1, 0, 0, 'h41); tick();
    wr(2, 1, 1, 'h55); reset = 1; tick();
    reset = 0; idle();
    chk("mid_avail", vc_available, 4'hF);
    chk("mid_empty", vc_empty, 4'hF);
    chk("mid_ov", bus.out_valid, 0);
    chk("mid_ovf", overflow_err, 0);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      idle();
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) < 6)
        wr($urandom_range(0, NV - 1),
           $urandom_range(0, 1),
           $urandom_range(0, 1),
           $urandom);
      if ($urandom_range(0, 9) < 5)
        rd($urandom_range(0, NV - 1));
      tick();
    end
    reset = 0; idle();
    tick(); tick();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/input_vc_buffer.md
# input_vc_buffer

Per-input-port flit storage unit that writes incoming link flits into per-VC FIFOs and hands them to the router pipeline. It is the write side of the VC buffer read by the router's buffer-read stage: the router drives a VC index and a read strobe per port, and this block pops the selected VC. It exposes head flits for route compute, per-VC availability for VC allocation, and returns credits upstream. One instance is placed per router input port.

## Interface
- NUM_VC, 4, virtual channels per port
- VC_DEPTH, 4, flit slots per VC (power of two, >= 2)
- FLIT_WIDTH, `FLIT_DATA_WIDTH, flit width; dest router ID in MSBs
- VC_BITS, $clog2(NUM_VC), VC index width
- CNT_BITS, $clog2(VC_DEPTH)+1, occupancy counter width

- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  flit present on link this cycle
- in_vc  input  VC_BITS  target VC of incoming flit
- in_head  input  1  incoming flit is a head flit
- in_tail  input  1  incoming flit is a tail flit (head+tail = single-flit packet)
- in_data  input  FLIT_WIDTH  incoming flit
- rd_valid  input  1  router read strobe (vc_read_valid bit for this port)
- rd_vc  input  VC_BITS  VC to pop (vc_index for this port)
- out_valid  output  1  registered: flit popped last cycle
- out_vc  output  VC_BITS  VC of out_data
- out_data  output  FLIT_WIDTH  popped flit
- head_data  output  [NUM_VC-1:0][FLIT_WIDTH]  current head flit of each VC (combinational from storage)
- vc_empty  output  NUM_VC  VC occupancy is zero
- vc_available  output  NUM_VC  VC is IDLE and empty (free for new packet)
- credit_valid  output  1  one slot freed last cycle
- credit_vc  output  VC_BITS  VC whose slot was freed
- overflow_err  output  1  sticky: write to full VC dropped

## Operation
- Per VC: circular FIFO with wr_ptr, rd_ptr (log2(VC_DEPTH) bits, wrap modulo VC_DEPTH) and occupancy count (CNT_BITS). Full when count == VC_DEPTH.
- Per-VC state: IDLE, ACTIVE.
  - IDLE -> ACTIVE: accepted write with in_head=1 and in_tail=0.
  - ACTIVE -> IDLE: pop of a flit whose stored tail bit is 1.
  - Single-flit packet (head+tail) written in IDLE: stays IDLE; vc_available deasserts because VC is non-empty.
  - Non-head flit written to IDLE VC is stored (no protocol checking).
- Storage holds FLIT_WIDTH data plus tail bit per slot.
- Write accepted when in_valid and (count < VC_DEPTH, or pop on same VC same cycle). Otherwise flit dropped, overflow_err set, held until reset.
- Read accepted when rd_valid and count[rd_vc] != 0; read of empty VC ignored (no out_valid, no credit, no state change).
- Same-VC write+pop in one cycle: both performed, count unchanged.
- Pointer wrap: VC_DEPTH-1 -> 0.
- Out-of-range in_vc / rd_vc (>= NUM_VC) ignored.

## Timing
- Write at edge N: head_data/vc_empty reflect it after edge N (visible cycle N+1).
- Pop requested in cycle N: out_valid/out_vc/out_data and credit_valid/credit_vc asserted in cycle N+1 for exactly one cycle; head_data advances after edge N.
- Reset (any cycle, including mid-packet): all pointers/counts 0, all VCs IDLE, out_valid=0, out_vc=0, out_data=0, credit_valid=0, credit_vc=0, overflow_err=0, vc_empty=all 1s, vc_available=all 1s. Storage contents not cleared; head_data undefined-but-ignored while empty.
- Inputs during reset cycle are ignored.

## Configuration
- CREDIT_RETURN_EN defined: credit_valid/credit_vc driven as above.
- Not defined: credit_valid and credit_vc tied 0; credit logic removed; all else unchanged.

## Test plan
- Reset then write head+tail flit 0xA5 to VC2 -> next cycle vc_empty=4'b1011, vc_available=4'b1011, head_data[2]=0xA5; pop VC2 -> following cycle out_valid=1, out_vc=2, out_data=0xA5, credit_vc=2, vc_available=4'b1111.
- Write 4 flits (head, body, body, tail) to VC1, then 5th flit -> 5th dropped, overflow_err=1; pops return 4 flits in order; VC1 stays ACTIVE until tail popped, then vc_available[1]=1.
- VC0 full (4 flits) with simultaneous write+pop on VC0 -> write accepted, count stays 4, no overflow_err; pointers wrap, order preserved over 8 flits.
- rd_valid=1 on empty VC3 -> out_valid=0, credit_valid=0, no state change.
- Interleaved writes to VC0 and VC3 on alternate cycles, pops alternating -> per-VC ordering preserved, out_vc matches.
- Reset asserted mid-packet with VC1 ACTIVE holding 2 flits -> next cycle all vc_available=1, out_valid=0, overflow_err=0; build without CREDIT_RETURN_EN -> credit_valid stays 0 throughout.
